mips_pc: RTL and testbench
==========================

// Module: mips_pc
// PURPOSE
//   Program counter register for the MIPS pipeline IF stage.
//   Holds the current fetch address and loads the next-PC value on a clock edge when
//   both stepping and writing are enabled.
//   Supplies combinational PC+4 (sequential fetch) and PC+8 (link address / delay slot).
//   Sits between the next-PC mux and instruction memory.
// PARAMETERS
//   SIZE_ADDR_PC   32     width of the PC and of every address port
//   RESET_VECTOR   32'h0  value loaded into the PC on reset
// PORTS
//   i_clk       in   1             single clock; all state updates on the rising edge
//   i_reset     in   1             synchronous, active-high reset
//   i_step      in   1             debug/step enable; 0 freezes the PC
//   i_pc_write  in   1             write enable from hazard unit; 0 = stall (hold PC)
//   i_NPC       in   SIZE_ADDR_PC  next PC value selected upstream
//   o_pc        out  SIZE_ADDR_PC  current PC (registered)
//   o_pc_4      out  SIZE_ADDR_PC  o_pc + 4 (combinational)
//   o_pc_8      out  SIZE_ADDR_PC  o_pc + 8 (combinational)
//   o_misalign  out  1             only with MIPS_PC_ALIGN_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//   - One clock, i_clk. Reset i_reset is synchronous and active-high. No asynchronous paths into the register.
//   - Rising edge of i_clk, in priority order:
//       1. i_reset = 1: pc_q <= RESET_VECTOR.
//       2. i_step = 1 and i_pc_write = 1: pc_q <= i_NPC.
//       3. Otherwise: pc_q holds its value.
//   - Reset outputs: o_pc = RESET_VECTOR, o_pc_4 = RESET_VECTOR+4, o_pc_8 = RESET_VECTOR+8.
//     With the default vector these are 0, 4 and 8.
//   - Latency: i_NPC appears on o_pc one cycle after it is sampled. o_pc_4 and o_pc_8
//     follow o_pc in the same cycle (pure combinational).
//   - Arithmetic: unsigned adds, modulo 2^SIZE_ADDR_PC. Carry is discarded, so the
//     outputs wrap around. Example: 0xFFFF_FFFC gives o_pc_4 = 0x0 and o_pc_8 = 0x4.
//   - i_NPC is loaded verbatim; no alignment masking is applied in the base build.
//   - Reset in the middle of a step/write cycle: reset wins, and i_NPC is discarded.
//   - i_step = 0 or i_pc_write = 0 holds the PC indefinitely, and i_NPC is ignored.
// CONFIGURATION
//   MIPS_PC_ALIGN_CHECK_EN
//     Defined:
//       - Adds output o_misalign, registered; reset value 0.
//       - On a load, o_misalign <= |i_NPC[1:0], and pc_q <= {i_NPC[SIZE-1:2], 2'b00}.
//       - o_misalign holds its value whenever the PC holds.
//     Undefined:
//       - No o_misalign port and no masking; i_NPC is loaded as-is.
// STRUCTURE
//   - Package mips_pc_pkg:
//       - localparam PC_INC_4 = 4, PC_INC_8 = 8.
//       - Default RESET_VECTOR.
//       - typedef-equivalent width constant SIZE_ADDR_PC.
//   - Sub-module pc_adder (parameterised width, constant increment):
//       - Instantiated twice, for +4 and +8.
//   - Top level contains only the enable logic and the PC register.
// TESTING
//   1. Reset: i_reset=1 for one edge -> o_pc=0x0, o_pc_4=0x4, o_pc_8=0x8.
//   2. Load: i_step=1, i_pc_write=1, i_NPC=0x1 -> next edge o_pc=0x1, o_pc_4=0x5, o_pc_8=0x9.
//   3. Stall: i_NPC=0x40 with i_pc_write=0, or with i_step=0, for 3 edges -> o_pc unchanged.
//   4. Wrap: load i_NPC=0xFFFF_FFFC -> o_pc_4=0x0000_0000, o_pc_8=0x0000_0004.
//   5. Priority: i_reset=1 with i_step=1, i_pc_write=1, i_NPC=0x100 -> o_pc=0x0.
//   6. With MIPS_PC_ALIGN_CHECK_EN: load 0x1003 -> o_pc=0x1000, o_misalign=1;
//      then load 0x2000 -> o_misalign=0.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared constants for the IF-stage program counter slice.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mips_pc_pkg;

    // Default width of the PC and of every address port
    localparam int unsigned DEF_SIZE_ADDR_PC = 32;

    // Default fetch address after reset
    localparam logic [DEF_SIZE_ADDR_PC-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

    // Constant increments: sequential fetch and link/delay-slot address
    localparam int unsigned PC_INC_4 = 4;
    localparam int unsigned PC_INC_8 = 8;

    // Word alignment: MIPS instructions live on 4-byte boundaries
    localparam int unsigned PC_ALIGN_BITS = 2;

    // True when a byte address is not on a word boundary
    function automatic logic is_misaligned(input logic [PC_ALIGN_BITS-1:0] low_bits);
        return |low_bits;
    endfunction

endpackage : mips_pc_pkg

// File: rtl/mips_pc_pc_adder.sv
// Adds a fixed increment to an address; the carry out of the top bit is dropped so results wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module pc_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INC   = 4
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_sum
);

    // Increment truncated to the address width, so the add is modulo 2^WIDTH
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    assign o_sum = i_a + INC_W;

endmodule : pc_adder

// File: rtl/mips_pc.sv
// Program counter register for the MIPS IF stage; loads i_NPC when both i_step and i_pc_write are high.
// Latency: i_NPC appears on o_pc one cycle after sampling; o_pc_4/o_pc_8 follow o_pc combinationally.
// Backpressure: i_step=0 or i_pc_write=0 holds the PC (and i_NPC is ignored); optional MIPS_PC_ALIGN_CHECK_EN adds o_misalign.
module mips_pc
    import mips_pc_pkg::*;
#(
    parameter int unsigned                   SIZE_ADDR_PC = DEF_SIZE_ADDR_PC,
    parameter logic [SIZE_ADDR_PC-1:0]       RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic                    i_pc_write,
    input  logic [SIZE_ADDR_PC-1:0] i_NPC,
    output logic [SIZE_ADDR_PC-1:0] o_pc,
    output logic [SIZE_ADDR_PC-1:0] o_pc_4,
    output logic [SIZE_ADDR_PC-1:0] o_pc_8
`ifdef MIPS_PC_ALIGN_CHECK_EN
    ,
    output logic                    o_misalign
`endif
);

    logic                    load_en;
    logic [SIZE_ADDR_PC-1:0] pc_d;
    logic [SIZE_ADDR_PC-1:0] pc_q;

    // Hazard stall and debug freeze must both be released for the PC to advance
    assign load_en = i_step & i_pc_write;

`ifdef MIPS_PC_ALIGN_CHECK_EN
    logic misalign_d;
    logic misalign_q;

    // Next-state: load word-aligned i_NPC and flag dropped low bits, else hold both
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (load_en) begin
            pc_d       = {i_NPC[SIZE_ADDR_PC-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
            misalign_d = is_misaligned(i_NPC[PC_ALIGN_BITS-1:0]);
        end
    end

    // PC and misalign flag registers; synchronous reset wins over any load
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_misalign = misalign_q;
`else
    // Next-state: load i_NPC verbatim when enabled, else hold
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = i_NPC;
        end
    end

    // PC register; synchronous reset wins over any load
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

    assign o_pc = pc_q;

    // Sequential fetch address
    pc_adder #(
        .WIDTH (SIZE_ADDR_PC),
        .INC   (PC_INC_4)
    ) u_add4 (
        .i_a   (pc_q),
        .o_sum (o_pc_4)
    );

    // Link address / address after the delay slot
    pc_adder #(
        .WIDTH (SIZE_ADDR_PC),
        .INC   (PC_INC_8)
    ) u_add8 (
        .i_a   (pc_q),
        .o_sum (o_pc_8)
    );

endmodule : mips_pc

// File: tb/tb_mips_pc.sv
// Directed bench for mips_pc: reset, load, stall, wrap, reset priority and optional alignment check.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stalls driven via i_pc_write and i_step.
module tb_mips_pc;

    logic        clk;
    logic        reset;
    logic        step;
    logic        pc_write;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] pc_8;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    logic        misalign;
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    int vectors;
    int miscompares;

    mips_pc dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_step     (step),
        .i_pc_write (pc_write),
        .i_NPC      (npc),
        .o_pc       (pc),
        .o_pc_4     (pc_4),
        .o_pc_8     (pc_8)
`ifdef MIPS_PC_ALIGN_CHECK_EN
        ,
        .o_misalign (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Expected PC after loading v: masked to a word boundary only in the alignment build
    function automatic logic [31:0] loaded(input logic [31:0] v);
        return ALIGN ? {v[31:2], 2'b00} : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        step     = 1'b0;
        pc_write = 1'b0;
        npc      = 32'h0;

        // Reset state
        tick();
        check("reset_pc",   pc,   32'h0000_0000);
        check("reset_pc4",  pc_4, 32'h0000_0004);
        check("reset_pc8",  pc_8, 32'h0000_0008);
`ifdef MIPS_PC_ALIGN_CHECK_EN
        check("reset_misalign", {31'b0, misalign}, 32'h0);
`endif

        // Load
        reset    = 1'b0;
        step     = 1'b1;
        pc_write = 1'b1;
        npc      = 32'h0000_0001;
        tick();
        check("load_pc",  pc,   loaded(32'h1));
        check("load_pc4", pc_4, loaded(32'h1) + 32'd4);
        check("load_pc8", pc_8, loaded(32'h1) + 32'd8);

        // Stall via pc_write = 0
        npc      = 32'h0000_0040;
        pc_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_write_pc", pc, loaded(32'h1));
        end

        // Stall via step = 0
        pc_write = 1'b1;
        step     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_step_pc", pc, loaded(32'h1));
        end

        // Release stall: 0x40 now loads
        step = 1'b1;
        tick();
        check("release_pc",  pc,   32'h0000_0040);
        check("release_pc4", pc_4, 32'h0000_0044);

        // Back-to-back loads
        npc = 32'h0000_0100;
        tick();
        check("b2b_pc0", pc, 32'h0000_0100);
        npc = 32'h0000_0200;
        tick();
        check("b2b_pc1", pc, 32'h0000_0200);

        // Wrap at the top of the address space
        npc = 32'hFFFF_FFFC;
        tick();
        check("wrap_pc",  pc,   32'hFFFF_FFFC);
        check("wrap_pc4", pc_4, 32'h0000_0000);
        check("wrap_pc8", pc_8, 32'h0000_0004);
        npc = 32'hFFFF_FFF8;
        tick();
        check("wrap2_pc4", pc_4, 32'hFFFF_FFFC);
        check("wrap2_pc8", pc_8, 32'h0000_0000);

        // Reset wins over a simultaneous load
        reset = 1'b1;
        npc   = 32'h0000_0100;
        tick();
        check("prio_pc",  pc,   32'h0000_0000);
        check("prio_pc4", pc_4, 32'h0000_0004);

        // Reset while the PC is stalled
        reset = 1'b0;
        npc   = 32'h0000_0300;
        tick();
        check("reload_pc", pc, 32'h0000_0300);
        pc_write = 1'b0;
        reset    = 1'b1;
        tick();
        check("stall_reset_pc", pc, 32'h0000_0000);
        reset    = 1'b0;
        pc_write = 1'b1;

`ifdef MIPS_PC_ALIGN_CHECK_EN
        // Misaligned load is masked and flagged
        npc = 32'h0000_1003;
        tick();
        check("align_pc",  pc, 32'h0000_1000);
        check("align_mis", {31'b0, misalign}, 32'h1);
        // Flag holds while stalled
        pc_write = 1'b0;
        npc      = 32'h0000_2000;
        tick();
        check("align_hold_mis", {31'b0, misalign}, 32'h1);
        check("align_hold_pc",  pc, 32'h0000_1000);
        // Aligned load clears the flag
        pc_write = 1'b1;
        tick();
        check("align_clr_pc",  pc, 32'h0000_2000);
        check("align_clr_mis", {31'b0, misalign}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mips_pc
